// File: rtl/minterm_sweep_checker_pkg.sv
// Shared constants, state encoding and expected-value lookup for the minterm sweep checker.
package minterm_sweep_checker_pkg;

  localparam int unsigned N_IN           = 6;
  localparam int unsigned NUM_VEC        = 64;
  localparam int unsigned ERR_W          = 7;
  localparam int unsigned SETTLE_W       = 4;
  localparam int unsigned DEF_SETTLE_CYC = 2;

  // Bit i is the golden Y for input vector i.
  localparam logic [NUM_VEC-1:0] EXP_MASK = 64'h0500_5500_1511_1511;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  function automatic logic expected_y(input logic [N_IN-1:0] idx);
    return EXP_MASK[idx];
  endfunction

endpackage

// File: rtl/minterm_vec_counter.sv
// Vector index register for the sweep: clear, increment and terminal-index flag.
module minterm_vec_counter
  import minterm_sweep_checker_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            inc_i,
  output logic [N_IN-1:0] idx_o,
  output logic            last_o
);

  logic [N_IN-1:0] idx_q;
  logic [N_IN-1:0] idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (inc_i) begin
      idx_d = idx_q + N_IN'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_q == {N_IN{1'b1}});

endmodule

// File: rtl/minterm_sweep_checker.sv
// Drives all 64 input vectors into the function block, samples Y after a settle
// window and accumulates mismatch statistics.
module minterm_sweep_checker
  import minterm_sweep_checker_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             y_in_i,
  output logic [N_IN-1:0]  vec_out_o,
  output logic             vec_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             mismatch_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [N_IN-1:0]  first_err_idx_o,
  output logic             first_err_valid_o,
  output logic             pass_o
);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);

  state_e             state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [N_IN-1:0]    vec_out_q, vec_out_d;
  logic               vec_valid_q, vec_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic [N_IN-1:0]    first_err_idx_q, first_err_idx_d;
  logic               first_err_valid_q, first_err_valid_d;

  logic               cnt_clr;
  logic               cnt_inc;
  logic [N_IN-1:0]    idx;
  logic               idx_last;
  logic               mismatch_c;

  minterm_vec_counter u_vec_counter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .idx_o  (idx),
    .last_o (idx_last)
  );

  // Next-state, counter control and registered-output next values.
  always_comb begin
    state_d           = state_q;
    settle_d          = settle_q;
    vec_out_d         = vec_out_q;
    err_cnt_d         = err_cnt_q;
    first_err_idx_d   = first_err_idx_q;
    first_err_valid_d = first_err_valid_q;
    cnt_clr           = 1'b0;
    cnt_inc           = 1'b0;
    mismatch_c        = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d           = S_DRIVE;
          cnt_clr           = 1'b1;
          vec_out_d         = '0;
          err_cnt_d         = '0;
          first_err_idx_d   = '0;
          first_err_valid_d = 1'b0;
        end
      end
      S_DRIVE: begin
        settle_d = '0;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      S_SAMPLE: begin
        mismatch_c = (y_in_i != expected_y(idx));
        if (mismatch_c) begin
          err_cnt_d = err_cnt_q + ERR_W'(1);
          if (!first_err_valid_q) begin
            first_err_idx_d   = idx;
            first_err_valid_d = 1'b1;
          end
        end
        // The final index ends the sweep; the counter is never wrapped back to 0.
        if (idx_last) begin
          state_d = S_DONE;
        end else begin
          cnt_inc   = 1'b1;
          vec_out_d = idx + N_IN'(1);
          state_d   = S_DRIVE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d      = (state_d == S_DRIVE) || (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    vec_valid_d = busy_d;
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q           <= S_IDLE;
      settle_q          <= '0;
      vec_out_q         <= '0;
      vec_valid_q       <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      err_cnt_q         <= '0;
      first_err_idx_q   <= '0;
      first_err_valid_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      settle_q          <= settle_d;
      vec_out_q         <= vec_out_d;
      vec_valid_q       <= vec_valid_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      err_cnt_q         <= err_cnt_d;
      first_err_idx_q   <= first_err_idx_d;
      first_err_valid_q <= first_err_valid_d;
    end
  end

  // The mismatch pulse must coincide with the sample cycle, so it is decoded directly.
  assign mismatch_o        = mismatch_c;
  assign vec_out_o         = vec_out_q;
  assign vec_valid_o       = vec_valid_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign err_cnt_o         = err_cnt_q;
  assign first_err_idx_o   = first_err_idx_q;
  assign first_err_valid_o = first_err_valid_q;
  assign pass_o            = done_q && (err_cnt_q == '0);

endmodule
